// File: rtl/lcd_bus_arbiter.sv
// HD44780-style LCD bus owner: power-up init, EN/setup/hold/exec timing, round-robin of two writers.
// Define LCD_ARB_INIT_EN to run the power-up wait and 38/0C/01/06 init sequence; otherwise IDLE follows reset.
module lcd_bus_arbiter #(
   parameter int unsigned T_POWERUP = 750000,
   parameter int unsigned T_SETUP   = 2,
   parameter int unsigned T_PULSE   = 12,
   parameter int unsigned T_EXEC    = 2000,
   parameter int unsigned T_CLEAR   = 82000
) (
   input  logic       Clock,
   input  logic       RST_N,
   input  logic       req0_valid,
   input  logic       req0_rs,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic       req1_rs,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       init_done,
   output logic       busy,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic [7:0] LCD_DATA
);

   localparam int unsigned CW = 20;

   typedef enum logic [2:0] {PWRUP, INIT, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt, cnt_load;
   logic [1:0]      init_idx;
   logic [7:0]      init_byte;
   logic            prefer1;
   logic            grant0, grant1, accept, clear_cmd;

   assign grant0    = req0_valid & (~req1_valid | ~prefer1);
   assign grant1    = req1_valid & (~req0_valid |  prefer1);
   assign accept    = req0_ready | req1_ready;
   assign clear_cmd = ~LCD_RS & ((LCD_DATA == 8'h01) | (LCD_DATA == 8'h02));

   always_comb begin
      init_byte = 8'h38;
      case (init_idx)
         2'd0: init_byte = 8'h38;
         2'd1: init_byte = 8'h0C;
         2'd2: init_byte = 8'h01;
         2'd3: init_byte = 8'h06;
         default: init_byte = 8'h38;
      endcase
   end

   always_ff @(posedge Clock or negedge RST_N) begin
      if (!RST_N) state <= PWRUP;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         PWRUP: if (cnt == CW'(T_POWERUP - 1)) state_next = INIT;
         INIT:  state_next = SETUP;
         SETUP: if (cnt == '0) state_next = PULSE;
         PULSE: if (cnt == '0) state_next = HOLD;
         HOLD:  if (cnt == '0) state_next = WAIT;
         WAIT:  if (cnt == '0) state_next = (init_done || init_idx == 2'd3) ? IDLE : INIT;
         IDLE:  if (accept) state_next = SETUP;
         default: state_next = PWRUP;
      endcase
`ifndef LCD_ARB_INIT_EN
      if (state == PWRUP) state_next = IDLE;
`endif
   end

   always_comb begin
      req0_ready = (state == IDLE) & grant0;
      req1_ready = (state == IDLE) & grant1;
      busy       = (state != IDLE);
      LCD_EN     = (state == PULSE);
      LCD_RW     = 1'b0;
   end

   always_comb begin
      cnt_load = '0;
      case (state_next)
         SETUP, HOLD: cnt_load = CW'(T_SETUP - 1);
         PULSE:       cnt_load = CW'(T_PULSE - 1);
         WAIT:        cnt_load = clear_cmd ? CW'(T_CLEAR - 1) : CW'(T_EXEC - 1);
         default:     cnt_load = '0;
      endcase
   end

   // PWRUP counts up from the reset value of 0; every other timed state counts down from its load.
   always_ff @(posedge Clock or negedge RST_N) begin
      if (!RST_N) begin
         cnt       <= '0;
         LCD_RS    <= 1'b0;
         LCD_DATA  <= 8'h00;
         prefer1   <= 1'b0;
         init_idx  <= 2'd0;
         init_done <= 1'b0;
      end else begin
         if (state_next != state)  cnt <= cnt_load;
         else if (state == PWRUP)  cnt <= cnt + 1'b1;
         else if (cnt != '0)       cnt <= cnt - 1'b1;

         if (state == INIT) begin
            LCD_RS   <= 1'b0;
            LCD_DATA <= init_byte;
         end

         if (accept) begin
            LCD_RS   <= req0_ready ? req0_rs   : req1_rs;
            LCD_DATA <= req0_ready ? req0_data : req1_data;
            prefer1  <= req0_ready;
         end

         if (state == WAIT && cnt == '0 && !init_done) begin
            if (init_idx == 2'd3) init_done <= 1'b1;
            else                  init_idx  <= init_idx + 1'b1;
         end
`ifndef LCD_ARB_INIT_EN
         if (state == PWRUP) init_done <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed, table-driven bench for lcd_bus_arbiter; init-sequence checks follow LCD_ARB_INIT_EN.
`timescale 1ns/1ps
module tb_lcd_bus_arbiter;

   localparam int unsigned T_POWERUP = 10;
   localparam int unsigned T_SETUP   = 2;
   localparam int unsigned T_PULSE   = 3;
   localparam int unsigned T_EXEC    = 5;
   localparam int unsigned T_CLEAR   = 20;
   localparam int EXEC_IDLE  = 1 + 2*T_SETUP + T_PULSE + T_EXEC;
   localparam int CLEAR_IDLE = 1 + 2*T_SETUP + T_PULSE + T_CLEAR;

   logic       Clock = 1'b0;
   logic       RST_N = 1'b0;
   logic       req0_valid = 1'b0, req0_rs = 1'b0;
   logic [7:0] req0_data = 8'h00;
   logic       req1_valid = 1'b0, req1_rs = 1'b0;
   logic [7:0] req1_data = 8'h00;
   logic       req0_ready, req1_ready, init_done, busy;
   logic       LCD_RS, LCD_RW, LCD_EN;
   logic [7:0] LCD_DATA;

   int checks = 0;
   int errors = 0;

   lcd_bus_arbiter #(
      .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE),
      .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR)
   ) dut (
      .Clock(Clock), .RST_N(RST_N),
      .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
      .init_done(init_done), .busy(busy),
      .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic       v0;
      logic       rs0;
      logic [7:0] d0;
      logic       v1;
      logic       rs1;
      logic [7:0] d1;
      logic       exp_r0;
      logic       exp_r1;
      logic       exp_rs;
      logic [7:0] exp_data;
      int         exp_idle;
   } vec_t;

   vec_t vecs [8];
   logic [7:0] init_b [4];
   int         init_gap [3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge Clock);
      while (busy && n < 300) begin
         @(negedge Clock);
         n++;
      end
      if (busy) check("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      int en_start, en_len, idle_at, bad;
      wait_idle();
      req0_valid = v.v0; req0_rs = v.rs0; req0_data = v.d0;
      req1_valid = v.v1; req1_rs = v.rs1; req1_data = v.d1;
      #1;
      check("grant0", req0_ready, v.exp_r0);
      check("grant1", req1_ready, v.exp_r1);
      @(posedge Clock);
      en_start = 0; en_len = 0; idle_at = 0; bad = 0;
      for (int c = 1; c <= 100 && idle_at == 0; c++) begin
         @(negedge Clock);
         if (c == 1 && (LCD_DATA !== v.exp_data || LCD_RS !== v.exp_rs)) bad++;
         if (LCD_EN) begin
            if (en_start == 0) en_start = c;
            en_len++;
            if (LCD_DATA !== v.exp_data || LCD_RS !== v.exp_rs || LCD_RW !== 1'b0) bad++;
         end
         if (busy) begin
            if (req0_ready || req1_ready) bad++;
         end else begin
            idle_at = c;
            if (!(req0_ready ^ req1_ready)) bad++;
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("en_start", en_start, 3);
      check("en_len", en_len, T_PULSE);
      check("next_ready", idle_at, v.exp_idle);
      check("bus_during_txn", bad, 0);
      check("data_held", LCD_DATA, v.exp_data);
   endtask

`ifdef LCD_ARB_INIT_EN
   task automatic check_init();
      int rises, fall, done_at, early, gap_bad, data_bad, first_rise;
      logic prev, rdy_at_done;
      rises = 0; fall = 0; done_at = 0; early = 0; gap_bad = 0; data_bad = 0; first_rise = 0;
      prev = 1'b0; rdy_at_done = 1'b0;
      req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h7E;
      for (int c = 1; c <= 400 && done_at == 0; c++) begin
         @(negedge Clock);
         if (LCD_EN && !prev) begin
            if (rises < 4 && (LCD_DATA !== init_b[rises] || LCD_RS !== 1'b0)) data_bad++;
            if (rises == 0) first_rise = c;
            else if (rises < 4 && c - fall != init_gap[rises-1]) gap_bad++;
            rises++;
         end
         if (!LCD_EN && prev) fall = c;
         prev = LCD_EN;
         if (init_done) begin
            done_at = c;
            rdy_at_done = req0_ready;
         end else if (req0_ready || !busy) early++;
      end
      req0_valid = 1'b0;
      check("init_pulses", rises, 4);
      check("init_first_rise", first_rise, T_POWERUP + 1 + T_SETUP);
      check("init_data", data_bad, 0);
      check("init_gaps", gap_bad, 0);
      check("init_done_at", done_at - fall, T_SETUP + T_EXEC);
      check("init_no_early_ready", early, 0);
      check("init_ready_after", rdy_at_done, 1'b1);
   endtask
`else
   task automatic check_no_init();
      req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h7E;
      @(negedge Clock);
      check("noinit_done", init_done, 1'b1);
      check("noinit_busy", busy, 1'b0);
      check("noinit_ready", req0_ready, 1'b1);
      req0_valid = 1'b0;
   endtask
`endif

   initial begin
      int got, both;
      init_b   = '{8'h38, 8'h0C, 8'h01, 8'h06};
      init_gap = '{2*T_SETUP + 1 + T_EXEC, 2*T_SETUP + 1 + T_EXEC, 2*T_SETUP + 1 + T_CLEAR};
      //            v0    rs0   d0     v1    rs1   d1     r0    r1    rs    data   idle
      vecs[0] = '{1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h41, EXEC_IDLE};
      vecs[1] = '{1'b1, 1'b1, 8'h30, 1'b1, 1'b1, 8'h31, 1'b0, 1'b1, 1'b1, 8'h31, EXEC_IDLE};
      vecs[2] = '{1'b1, 1'b1, 8'h32, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h32, EXEC_IDLE};
      vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 8'h01, CLEAR_IDLE};
      vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, EXEC_IDLE};
      vecs[5] = '{1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h02, CLEAR_IDLE};
      vecs[6] = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h03, EXEC_IDLE};
      vecs[7] = '{1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h02, EXEC_IDLE};

      // Reset values, with requests pending to confirm they are held off.
      req0_valid = 1'b1; req1_valid = 1'b1;
      repeat (3) @(negedge Clock);
      check("rst_en", LCD_EN, 1'b0);
      check("rst_rs", LCD_RS, 1'b0);
      check("rst_rw", LCD_RW, 1'b0);
      check("rst_data", LCD_DATA, 8'h00);
      check("rst_ready", {req0_ready, req1_ready}, 2'b00);
      check("rst_init_done", init_done, 1'b0);
      check("rst_busy", busy, 1'b1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      RST_N = 1'b1;
`ifdef LCD_ARB_INIT_EN
      check_init();
`else
      check_no_init();
`endif

      wait_idle();
      #1;
      check("no_valid_no_ready", {req0_ready, req1_ready}, 2'b00);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Both requesters valid continuously: grants must alternate starting with req0.
      wait_idle();
      both = 0;
      req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'hA0;
      req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'hB1;
      for (int g = 0; g < 4; g++) begin
         got = -1;
         for (int c = 0; c < 100 && got < 0; c++) begin
            if (c > 0 || g > 0) @(negedge Clock);
            #1;
            if (req0_ready && req1_ready) both++;
            else if (req0_ready) got = 0;
            else if (req1_ready) got = 1;
         end
         check("alt_grant", got, g % 2);
         @(posedge Clock);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("never_both_ready", both, 0);

      // Reset asserted in the middle of an EN pulse.
      wait_idle();
      req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h48;
      @(posedge Clock);
      #1 req0_valid = 1'b0;
      got = 0;
      for (int c = 0; c < 20 && !LCD_EN; c++) begin
         @(negedge Clock);
         got = c;
      end
      check("pulse_seen", LCD_EN, 1'b1);
      @(posedge Clock);
      #2 RST_N = 1'b0;
      #1;
      check("midrst_en", LCD_EN, 1'b0);
      check("midrst_busy", busy, 1'b1);
      check("midrst_init_done", init_done, 1'b0);
      check("midrst_data", LCD_DATA, 8'h00);
      @(negedge Clock);
      RST_N = 1'b1;
`ifdef LCD_ARB_INIT_EN
      check_init();
`else
      check_no_init();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
